// File: rtl/fmadd_mul_seq_core.sv
// fmadd_mul_seq_core
//   Iterative radix-2 shift-add multiplier front end for the FMADD
//   multiplication path. Accepts two packed IEEE operands and emits the
//   unrounded product word for the multiplication rounding stage.
//
// Ports
//   clk            clock
//   rst_l          asynchronous active-low reset
//   in_valid       operands valid
//   in_ready       idle, can accept (high only in IDLE)
//   in_a, in_b     packed operands {sign, exponent, fraction}
//   in_rm          rounding mode, captured at accept
//   out_valid      result valid (DONE)
//   out_ready      downstream accepts
//   out_no         {sign, 9-bit exponent, 2*(MAN+2)-bit mantissa},
//                  hidden bit at MAN+MAN+3
//   out_sticky_pn  OR of bits shifted out during denormalisation
//   out_rm         captured rounding mode
//
// Build option
//   FMADD_MUL_EARLY_TERM_EN  when defined, MUL leaves as soon as the
//                            remaining multiplier bits are all zero.
module fmadd_mul_seq_core #(
  parameter int STD  = 31,
  parameter int MAN  = 22,
  parameter int EXP  = 7,
  parameter int BIAD = 127
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [STD:0]           in_a,
  input  logic [STD:0]           in_b,
  input  logic [2:0]             in_rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MAN+MAN+EXP+6:0] out_no,
  output logic                   out_sticky_pn,
  output logic [2:0]             out_rm
);

  localparam int MW = MAN + 2;       // operand mantissa width
  localparam int PW = 2 * MAN + 4;   // product width
  localparam int EW = EXP + 4;       // signed working exponent width
  localparam int XW = EXP + 2;       // output exponent field width
  localparam int CW = $clog2(MW);    // multiplier bit counter width

  typedef enum logic [1:0] {IDLE, MUL, ADJ, DONE} state_t;

  state_t state_q, state_d;

  logic                 sign_q;
  logic signed [EW-1:0] e_q;
  logic [PW-1:0]        p_q;
  logic [PW-1:0]        mcand_q;
  logic [MW-1:0]        mplier_q;
  logic [CW-1:0]        cnt_q;
  logic                 sticky_q;
  logic [2:0]           rm_q;

  // Operand unpacking
  logic [EXP:0]         ea_f, eb_f, ea_eff, eb_eff;
  logic [MW-1:0]        ma_in, mb_in;
  logic signed [EW-1:0] e_in;

  assign ea_f = in_a[STD-1 -: EXP+1];
  assign eb_f = in_b[STD-1 -: EXP+1];
  // max(E,1): a zero field becomes 1, any other value is left untouched
  assign ea_eff = ea_f | {{EXP{1'b0}}, ~|ea_f};
  assign eb_eff = eb_f | {{EXP{1'b0}}, ~|eb_f};
  assign ma_in  = {|ea_f, in_a[MAN:0]};
  assign mb_in  = {|eb_f, in_b[MAN:0]};
  assign e_in   = EW'(ea_eff) + EW'(eb_eff) - EW'(BIAD - 1);

  // Multiply termination
  logic mul_last;
`ifdef FMADD_MUL_EARLY_TERM_EN
  assign mul_last = (cnt_q == CW'(MW - 1)) || (mplier_q[MW-1:1] == '0);
`else
  assign mul_last = (cnt_q == CW'(MW - 1));
`endif

  // Adjust-step decode, highest priority first. A flush always finishes
  // in the same cycle because P=0, e=1 fails every later shift test.
  logic adj_zero, adj_flush, adj_rsh, adj_lsh, adj_fin;

  always_comb begin
    adj_zero  = (p_q == '0);
    adj_flush = !adj_zero && (int'(e_q) < -PW);
    adj_rsh   = !adj_zero && !adj_flush && (int'(e_q) < 1);
    adj_lsh   = !adj_zero && !adj_flush && !adj_rsh &&
                !p_q[PW-1] && (int'(e_q) > 1);
    adj_fin   = !(adj_rsh || adj_lsh);
  end

  // State register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)  state_d = MUL;
      MUL:  if (mul_last)  state_d = ADJ;
      ADJ:  if (adj_fin)   state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sign_q   <= 1'b0;
      e_q      <= '0;
      p_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      rm_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q   <= in_a[STD] ^ in_b[STD];
            e_q      <= e_in;
            p_q      <= '0;
            mcand_q  <= PW'(ma_in);
            mplier_q <= mb_in;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            rm_q     <= in_rm;
          end
        end
        MUL: begin
          // Multiplicand shifts left while the multiplier shifts right,
          // so bit 0 of mplier_q always pairs with Ma<<i.
          if (mplier_q[0]) p_q <= p_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
        end
        ADJ: begin
          if (adj_zero) begin
            e_q <= EW'(1);
          end else if (adj_flush) begin
            sticky_q <= 1'b1;
            p_q      <= '0;
            e_q      <= EW'(1);
          end else if (adj_rsh) begin
            sticky_q <= sticky_q | p_q[0];
            p_q      <= p_q >> 1;
            e_q      <= e_q + EW'(1);
          end else if (adj_lsh) begin
            p_q <= p_q << 1;
            e_q <= e_q - EW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Unnormalised results encode as exponent 0 with hidden bit 0
  assign out_no        = {sign_q, (p_q[PW-1] ? e_q[XW-1:0] : {XW{1'b0}}), p_q};
  assign out_sticky_pn = sticky_q;
  assign out_rm        = rm_q;

endmodule
